vmicro16_uart_rx: RTL and testbench

UART receiver for the vmicro16 SoC, the receive counterpart of the SoC's `uart_tx` serial output. It is fed from the board RXD pin and oversamples the asynchronous line on the system clock. Each 8N1 frame is deserialised LSB-first, and received bytes are buffered for the CPU-side peripheral logic. Frame errors and overruns are reported through sticky flags.

---
 rtl/vmicro16_uart_pkg.sv | 20 ++
 rtl/vmicro16_sync_fifo.sv | 52 +++++
 rtl/vmicro16_uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_vmicro16_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmicro16_uart_pkg.sv
// Shared UART definitions for the vmicro16 receiver and transmitter:
// frame constants, receiver state encoding and the bit-period helper.
package vmicro16_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // System clocks per serial bit, integer-truncated.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/vmicro16_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// DEPTH must be a power of two (pointers wrap naturally). A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module vmicro16_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and count; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

endmodule

// File: rtl/vmicro16_uart_rx.sv
// vmicro16 UART receiver: 8N1, LSB first, oversampled on the system clock.
// Optional feature macro VMICRO16_UART_RX_FIFO_EN: when defined, received
// bytes go into a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
// Handshake: a byte is consumed on any rising edge where rx_valid & rx_ready;
// rx_ready with rx_valid low has no effect.
// dbg_state exposes the receiver FSM state for observation.
module vmicro16_uart_rx import vmicro16_uart_pkg::*; #(
    parameter  int CLK_HZ     = 50_000_000,
    parameter  int BAUD       = 115200,
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rxd,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [CW-1:0] rx_count,
    output logic          frame_err,
    output logic          overrun,
    input  logic          err_clr,
    output logic [1:0]    dbg_state
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int TW  = $clog2(CPB + 1);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CPB - 1);

    logic            r_sync1, r_sync2, w_rxs;
    logic [1:0]      r_prime;
    logic            r_armed;
    rx_state_t       r_state, w_state_next;
    logic [TW-1:0]   r_timer;
    logic [BW-1:0]   r_bit_cnt;
    logic [7:0]      r_shift;
    logic            w_tick, w_load_half, w_load_full, w_shift_en;
    logic            w_push, w_frame_evt, w_overrun_evt, w_pop, w_full;

    assign w_rxs     = r_sync2;
    assign w_tick    = (r_timer == '0);
    assign w_pop     = rx_valid & rx_ready;
    assign dbg_state = r_state;

    // Two-flop synchroniser; r_prime marks when r_sync2 reflects the real line
    // rather than its reset value, so a line held low through reset cannot arm.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prime <= 2'b00;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    // Arm once the line is seen idle-high; disarm on start so a low stop bit
    // (break) cannot immediately retrigger a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                      r_armed <= 1'b0;
        else if (w_load_half)                              r_armed <= 1'b0;
        else if (r_state == RX_IDLE && w_rxs && r_prime[1]) r_armed <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RX_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        w_state_next = r_state;
        w_load_half  = 1'b0;
        w_load_full  = 1'b0;
        w_shift_en   = 1'b0;
        w_push       = 1'b0;
        w_frame_evt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_armed && !w_rxs) begin
                    w_state_next = RX_START;
                    w_load_half  = 1'b1;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (!w_rxs) begin
                        w_state_next = RX_DATA;
                        w_load_full  = 1'b1;
                    end else begin
                        w_state_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_shift_en  = 1'b1;
                    w_load_full = 1'b1;
                    if (r_bit_cnt == BW'(DATA_BITS - 1)) w_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_state_next = RX_IDLE;
                    w_push       = w_rxs;
                    w_frame_evt  = ~w_rxs;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // Bit timer, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_load_half)      r_timer <= HALF_LOAD;
            else if (w_load_full) r_timer <= FULL_LOAD;
            else if (!w_tick)     r_timer <= r_timer - 1'b1;
            if (w_load_half)     r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift_en) r_shift <= {w_rxs, r_shift[7:1]};
        end
    end

`ifdef VMICRO16_UART_RX_FIFO_EN
    logic w_empty;

    vmicro16_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (rx_ready),
        .o_data  (rx_data),
        .o_count (rx_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid = ~w_empty;
`else
    logic [7:0] r_hold;
    logic       r_hold_valid;

    // Single holding register; a simultaneous pop frees the slot for the push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_push && (!r_hold_valid || w_pop)) begin
            r_hold       <= r_shift;
            r_hold_valid <= 1'b1;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign rx_data  = r_hold;
    assign rx_valid = r_hold_valid;
    assign rx_count = CW'(r_hold_valid);
    assign w_full   = r_hold_valid;
`endif

    assign w_overrun_evt = w_push & w_full & ~w_pop;

    // Sticky error flags; a new event wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_frame_evt)  frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (w_overrun_evt) overrun <= 1'b1;
            else if (err_clr)  overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vmicro16_uart_rx.sv
// Directed testbench for vmicro16_uart_rx at 50 MHz / 115200 baud (434 clocks per bit).
// Tests adapt to VMICRO16_UART_RX_FIFO_EN being defined or not.
module tb_vmicro16_uart_rx;
    import vmicro16_uart_pkg::*;

    localparam int CPB = 434;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    vmicro16_uart_rx #(
        .CLK_HZ     (50_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver: one full 8N1 frame, every bit held CPB clocks, changes on negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    // Driver: wait (bounded) for a byte, take it, and pop it.
    task automatic pop_byte(output logic [7:0] d, input int budget);
        int n = 0;
        while (rx_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rx_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL pop_timeout: rx_valid=%b after %0d clocks, required 1", rx_valid, n);
            d = 8'hxx;
        end else begin
            d = rx_data;
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (rx_data   !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        total++; if (rx_valid  !== 1'b0)  begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_count  !== 4'd0)  begin bad++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (overrun   !== 1'b0)  begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (dbg_state !== RX_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
`ifdef VMICRO16_UART_RX_FIFO_EN
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        repeat (5) @(negedge clk);
        total++; if (rx_count !== 4'd2) begin bad++; $display("FAIL b2b_count_peak: got %0d want 2", rx_count); end
        pop_byte(d1, 100);
        pop_byte(d2, 100);
`else
        fork
            begin
                send_byte(8'h55, 1'b1);
                send_byte(8'hA3, 1'b1);
            end
            begin
                pop_byte(d1, 12000);
                pop_byte(d2, 12000);
            end
        join
`endif
        total++; if (d1 !== 8'h55) begin bad++; $display("FAIL b2b_first: got %h want 55", d1); end
        total++; if (d2 !== 8'hA3) begin bad++; $display("FAIL b2b_second: got %h want a3", d2); end
        @(negedge clk);
        total++; if (rx_valid  !== 1'b0) begin bad++; $display("FAIL b2b_empty: rx_valid=%b want 0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL b2b_frame_err: got %b want 0", frame_err); end
        total++; if (overrun   !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_false_start();
        logic [7:0] d;
        repeat (CPB) @(negedge clk);
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        total++; if (dbg_state !== RX_START) begin bad++; $display("FAIL glitch_in_start: state=%0d want 1", dbg_state); end
        repeat (250) @(negedge clk);
        total++; if (dbg_state !== RX_IDLE) begin bad++; $display("FAIL glitch_back_idle: state=%0d want 0", dbg_state); end
        repeat (CPB * 10) @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_no_byte: rx_valid=%b want 0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
        send_byte(8'h3C, 1'b1);
        pop_byte(d, 100);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL glitch_next_byte: got %h want 3c", d); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        repeat (CPB) @(negedge clk);
        send_byte(8'hF0, 1'b0);
        repeat (CPB) @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        total++; if (rx_valid  !== 1'b0) begin bad++; $display("FAIL ferr_no_push: rx_valid=%b want 0", rx_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
        send_byte(8'h0F, 1'b1);
        pop_byte(d, 100);
        total++; if (d !== 8'h0F) begin bad++; $display("FAIL ferr_next_byte: got %h want 0f", d); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_stays_clear: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
`ifdef VMICRO16_UART_RX_FIFO_EN
        logic [7:0] d;
        for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
        repeat (5) @(negedge clk);
        total++; if (rx_count !== 4'd8) begin bad++; $display("FAIL ovr_count: got %0d want 8", rx_count); end
        total++; if (overrun  !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        for (int i = 0; i < 8; i++) begin
            pop_byte(d, 100);
            total++; if (d !== 8'(i)) begin bad++; $display("FAIL ovr_pop_%0d: got %h want %h", i, d, 8'(i)); end
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_lost_byte: rx_valid=%b want 0", rx_valid); end
        total++; if (rx_count !== 4'd0) begin bad++; $display("FAIL ovr_count_empty: got %0d want 0", rx_count); end
`else
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (5) @(negedge clk);
        total++; if (rx_data  !== 8'h11) begin bad++; $display("FAIL ovr_data: got %h want 11", rx_data); end
        total++; if (overrun  !== 1'b1)  begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        total++; if (rx_count !== 4'd1)  begin bad++; $display("FAIL ovr_count: got %0d want 1", rx_count); end
        total++; if (rx_valid !== 1'b1)  begin bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        repeat (CPB) @(negedge clk);
        // 0x81 LSB first: start, bit0=1, then bits 1.. low; reset during bit 2
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        rxd = 1'b0;
        repeat (CPB + 200) @(negedge clk);
        total++; if (dbg_state !== RX_DATA) begin bad++; $display("FAIL rst_mid_in_data: state=%0d want 2", dbg_state); end
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (rx_valid  !== 1'b0)  begin bad++; $display("FAIL rst_mid_valid: got %b want 0", rx_valid); end
        total++; if (rx_count  !== 4'd0)  begin bad++; $display("FAIL rst_mid_count: got %0d want 0", rx_count); end
        total++; if (rx_data   !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %h want 00", rx_data); end
        total++; if (overrun   !== 1'b0)  begin bad++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
        repeat (2000) @(negedge clk);
        total++; if (dbg_state !== RX_IDLE) begin bad++; $display("FAIL rst_low_no_start: state=%0d want 0", dbg_state); end
        repeat (3000) @(negedge clk);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_low_frame_err: got %b want 0", frame_err); end
        total++; if (rx_valid  !== 1'b0) begin bad++; $display("FAIL rst_low_no_byte: rx_valid=%b want 0", rx_valid); end
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        pop_byte(d, 100);
        total++; if (d !== 8'h7E) begin bad++; $display("FAIL rst_next_byte: got %h want 7e", d); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
